alu_md_controller: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder for the Simple_Single_CPU RISC-V core. It decodes the full RV32I/RV32M ALU operation set from ALUop/funct3/funct7 into a 4-bit ALU control code. It also contains an iterative radix-2 multiply/divide engine that stalls the core while an M-extension instruction executes. It sits between the main Decoder and the ALU; its result is muxed into the register writeback path.

---
 rtl/alu_md_controller.sv | 209 ++++++++++++++++++++
 tb/tb_alu_md_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_controller.sv
// rtl/alu_md_controller.sv - RV32I/M ALU control decoder with iterative radix-2 multiply/divide engine
module alu_md_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      ALUop_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      ALUctrl_o,
  output logic            stall_o,
  output logic            md_busy_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SRA  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_MD   = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000: base_op = CTRL_ADD;
      3'b001: base_op = CTRL_SLL;
      3'b010: base_op = CTRL_SLT;
      3'b011: base_op = CTRL_SLTU;
      3'b100: base_op = CTRL_XOR;
      3'b101: base_op = CTRL_SRL;
      3'b110: base_op = CTRL_OR;
      3'b111: base_op = CTRL_AND;
    endcase
  endfunction

  logic [3:0] ctrl;
  logic       is_md;

  always_comb begin
    ctrl = CTRL_ADD;
    case (ALUop_i)
      2'b00: ctrl = CTRL_ADD;
      2'b01: ctrl = CTRL_SUB;
      2'b10: begin
        if (funct7_i == 7'b0000001)                  ctrl = CTRL_MD;
        else if (funct7_i[5] && funct3_i == 3'b000)  ctrl = CTRL_SUB;
        else if (funct7_i[5] && funct3_i == 3'b101)  ctrl = CTRL_SRA;
        else                                          ctrl = base_op(funct3_i);
      end
      2'b11: begin
        if (funct3_i == 3'b000)       ctrl = CTRL_ADD;
        else if (funct3_i == 3'b101)  ctrl = funct7_i[5] ? CTRL_SRA : CTRL_SRL;
        else                          ctrl = base_op(funct3_i);
      end
    endcase
  end

  assign is_md     = (ctrl == CTRL_MD);
  assign ALUctrl_o = ctrl;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand preparation at accept: magnitudes plus the sign the result must carry
  logic            is_mul, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    is_mul   = ~funct3_i[2];
    a_signed = (funct3_i == 3'b001) | (funct3_i == 3'b010) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    b_signed = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    a_neg    = a_signed & rs1_i[XLEN-1];
    b_neg    = b_signed & rs2_i[XLEN-1];
    abs_a    = a_neg ? -rs1_i : rs1_i;
    abs_b    = b_neg ? -rs2_i : rs2_i;
    div_zero = ~is_mul & (rs2_i == '0);
    div_ovf  = ~is_mul & ~funct3_i[0] & (rs1_i == SMIN) & (rs2_i == '1);
  end

  logic [XLEN:0]     mul_upper, rem_sh, rem_new;
  logic              div_ge;
  logic [2*XLEN-1:0] step, step_neg;
  logic [XLEN-1:0]   mul_res, div_sel, div_res, final_res;

  always_comb begin
    mul_upper = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? opb_q : {(XLEN+1){1'b0}});
    rem_sh    = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge    = (rem_sh >= opb_q);
    rem_new   = div_ge ? (rem_sh - opb_q) : rem_sh;
    step      = f3_q[2] ? {rem_new[XLEN-1:0], prod_q[XLEN-2:0], div_ge}
                        : {mul_upper, prod_q[XLEN-1:1]};
    step_neg  = -step;
    if (f3_q == 3'b000) mul_res = neg_q ? step_neg[XLEN-1:0] : step[XLEN-1:0];
    else                mul_res = neg_q ? step_neg[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    div_sel   = f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    div_res   = neg_q ? -div_sel : div_sel;
    final_res = f3_q[2] ? div_res : mul_res;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    res_d   = res_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && is_md) begin
          f3_d  = funct3_i;
          cnt_d = CW'(XLEN);
          if (is_mul) begin
            prod_d = {{XLEN{1'b0}}, abs_b};
            opb_d  = {1'b0, abs_a};
            neg_d  = a_neg ^ b_neg;
          end else begin
            prod_d = {{XLEN{1'b0}}, abs_a};
            opb_d  = {1'b0, abs_b};
            neg_d  = funct3_i[1] ? a_neg : (a_neg ^ b_neg);
          end
          if (div_zero) begin
            res_d   = funct3_i[1] ? rs1_i : '1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (div_ovf) begin
            res_d   = funct3_i[1] ? '0 : SMIN;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (!valid_i) begin
          state_d = S_IDLE;
        end else begin
          prod_d = step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = final_res;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign stall_o     = rst_i & valid_i & is_md & (state_q != S_DONE);
  assign md_busy_o   = busy_q;
  assign md_done_o   = done_q;
  assign md_result_o = res_q;
endmodule

// File: tb/tb_alu_md_controller.sv
// tb/tb_alu_md_controller.sv - self-checking bench for alu_md_controller
module tb_alu_md_controller;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic [1:0]      ALUop_i;
  logic [2:0]      funct3_i;
  logic [6:0]      funct7_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [3:0]      ALUctrl_o;
  logic            stall_o;
  logic            md_busy_o;
  logic            md_done_o;
  logic [XLEN-1:0] md_result_o;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_md_controller #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUop_i(ALUop_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .ALUctrl_o(ALUctrl_o), .stall_o(stall_o), .md_busy_o(md_busy_o),
    .md_done_o(md_done_o), .md_result_o(md_result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic run_md(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                        input int exp_lat, output int t_acc, output int t_done);
    int stalls;
    int lat;
    bit seen;
    logic [XLEN-1:0] e;
    @(negedge clk_i);
    valid_i = 1'b1; ALUop_i = 2'b10; funct7_i = 7'h01; funct3_i = f3; rs1_i = a; rs2_i = b;
    exp_q.push_back(exp_res);
    t_acc = cyc; t_done = -1; lat = -1; seen = 1'b0;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL %s stall_at_accept got %b want 1", name, stall_o); end
    vectors++;
    if (ALUctrl_o !== 4'b1111) begin errors++; $display("FAIL %s md_ctrl got %b want 1111", name, ALUctrl_o); end
    stalls = 1;
    for (int n = 1; n <= exp_lat + 4 && !seen; n++) begin
      @(negedge clk_i);
      vectors++;
      if (md_busy_o !== (n < exp_lat)) begin
        errors++; $display("FAIL %s busy_cycle_%0d got %b want %b", name, n, md_busy_o, (n < exp_lat));
      end
      if (stall_o === 1'b1) stalls++;
      if (md_done_o === 1'b1) begin
        seen = 1'b1; lat = n; t_done = cyc;
      end
      if (n == 1) begin rs1_i = $urandom; rs2_i = $urandom; end
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout got none want latency %0d", name, exp_lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      if (lat != exp_lat) begin errors++; $display("FAIL %s done_latency got %0d want %0d", name, lat, exp_lat); end
      vectors++;
      if (stalls != exp_lat) begin errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_lat); end
      vectors++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL %s scoreboard_empty got %h want none", name, md_result_o);
      end else begin
        e = exp_q.pop_front();
        if (md_result_o !== e) begin errors++; $display("FAIL %s result got %h want %h", name, md_result_o, e); end
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; valid_i = 1'b1; ALUop_i = 2'b10; funct7_i = 7'h01; funct3_i = 3'b000;
    rs1_i = 32'd3; rs2_i = 32'd4;
    #22;
    vectors++;
    if (md_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", md_busy_o); end
    vectors++;
    if (md_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", md_done_o); end
    vectors++;
    if (md_result_o !== '0) begin errors++; $display("FAIL reset_result got %h want 0", md_result_o); end
    vectors++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
    @(negedge clk_i);
    valid_i = 1'b0; rst_i = 1'b1;
  endtask

  task automatic test_decode;
    logic [1:0] ops[12] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [6:0] f7s[12] = '{7'h20, 7'h20, 7'h20, 7'h01, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h01, 7'h01, 7'h20};
    logic [2:0] f3s[12] = '{3'b000, 3'b000, 3'b101, 3'b011, 3'b000, 3'b000, 3'b111, 3'b101, 3'b101, 3'b000, 3'b100, 3'b010};
    logic [3:0] exp[12] = '{4'b0110, 4'b0010, 4'b1000, 4'b1111, 4'b0110, 4'b0010, 4'b0000, 4'b1000, 4'b0101, 4'b0010, 4'b0011, 4'b0111};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      ALUop_i = ops[i]; funct7_i = f7s[i]; funct3_i = f3s[i]; valid_i = (exp[i] != 4'b1111);
      #1;
      vectors++;
      if (ALUctrl_o !== exp[i]) begin errors++; $display("FAIL decode_%0d got %b want %b", i, ALUctrl_o, exp[i]); end
      vectors++;
      if (stall_o !== 1'b0 || md_busy_o !== 1'b0) begin
        errors++; $display("FAIL decode_engine_%0d got stall %b busy %b want 0 0", i, stall_o, md_busy_o);
      end
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_mul;
    int ta, td;
    run_md("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, ta, td);
    @(negedge clk_i);
    vectors++;
    if (md_result_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL result_hold got %h want ffffffeb", md_result_o); end
    run_md("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, ta, td);
    run_md("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, ta, td);
    run_md("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, ta, td);
  endtask

  task automatic test_div;
    int ta, td;
    run_md("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, ta, td);
    run_md("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, ta, td);
    run_md("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, ta, td);
    run_md("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33, ta, td);
  endtask

  task automatic test_edge;
    int ta, td;
    run_md("divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, ta, td);
    run_md("rem_zero", 3'b110, 32'd5, 32'd0, 32'd5, 1, ta, td);
    run_md("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, ta, td);
    run_md("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, ta, td);
  endtask

  task automatic test_flush;
    int pulses;
    @(negedge clk_i);
    valid_i = 1'b1; ALUop_i = 2'b10; funct7_i = 7'h01; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'd3;
    repeat (10) @(negedge clk_i);
    vectors++;
    if (md_busy_o !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b want 1", md_busy_o); end
    valid_i = 1'b0;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall_o); end
    @(negedge clk_i);
    vectors++;
    if (md_busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %b want 0", md_busy_o); end
    pulses = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (md_done_o === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin errors++; $display("FAIL flush_done_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid;
    int ta, td;
    @(negedge clk_i);
    valid_i = 1'b1; ALUop_i = 2'b10; funct7_i = 7'h01; funct3_i = 3'b000; rs1_i = 32'd9; rs2_i = 32'd9;
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    vectors++;
    if (md_busy_o !== 1'b0 || md_done_o !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got busy %b done %b want 0 0", md_busy_o, md_done_o);
    end
    vectors++;
    if (md_result_o !== '0) begin errors++; $display("FAIL midreset_result got %h want 0", md_result_o); end
    vectors++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL midreset_stall got %b want 0", stall_o); end
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0;
    run_md("after_reset_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, ta, td);
  endtask

  task automatic test_back_to_back;
    int ta1, td1, ta2, td2;
    run_md("b2b_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, ta1, td1);
    run_md("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, ta2, td2);
    vectors++;
    if (ta2 - ta1 != 34) begin errors++; $display("FAIL b2b_accept got T+%0d want T+34", ta2 - ta1); end
    vectors++;
    if (td2 - ta1 != 67) begin errors++; $display("FAIL b2b_done got T+%0d want T+67", td2 - ta1); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_mul;
    test_div;
    test_edge;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
